apb_slave_mem: RTL
==================

# apb_slave_mem

APB3 completer: a word-addressed register memory with a fixed, parameterised number of wait states and PSLVERR on bad addresses. It is the DUT behind the APB UVM environment. The agent's driver acts as requester, and the monitor, predictor and scoreboard check this block's responses. One transfer is in flight at a time; there is no buffering beyond the storage array.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width in bits (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32.
- MEM_DEPTH, 32, number of words; must be ≤ 2**(ADDR_WIDTH-2).
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0–15).

Ports:
- PCLK, input, 1, sole clock; all state changes on the rising edge.
- PRESETn, input, 1, reset; asynchronous assert, active-low.
- PSEL, input, 1, completer select.
- PENABLE, input, 1, access-phase indicator.
- PWRITE, input, 1, 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH, byte address.
- PWDATA, input, DATA_WIDTH, write data.
- PRDATA, output, DATA_WIDTH, read data; valid when PREADY=1 on a read.
- PREADY, output, 1, transfer completes this cycle.
- PSLVERR, output, 1, error response; valid only when PREADY=1.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE→SETUP on PSEL=1, PENABLE=0.
  - Latch PADDR, PWRITE and PWDATA.
  - Load wait counter = WAIT_STATES.
- SETUP→ACCESS on PSEL=1, PENABLE=1.
- SETUP→IDLE if PSEL falls.
- ACCESS:
  - Counter decrements each cycle while nonzero.
  - PREADY=1 in the cycle the counter reads 0.
- Completion cycle (PSEL & PENABLE & PREADY), then next state:
  - SETUP if the requester immediately starts a new setup (PSEL=1, PENABLE=0 next cycle).
  - IDLE otherwise.
- Error = PADDR[1:0]≠0 OR PADDR[ADDR_WIDTH-1:2] ≥ MEM_DEPTH.
- Write, no error: mem[PADDR[ADDR_WIDTH-1:2]] ← latched PWDATA at the completion edge.
- Read, no error: PRDATA = stored word.
- Errored transfer:
  - PSLVERR=1 with PREADY.
  - Write: memory unchanged.
  - Read: PRDATA=0.
- PSEL dropped during ACCESS:
  - Abort to IDLE; no write.
  - PREADY, PSLVERR cleared next cycle.
- PENABLE=1 seen in IDLE without a prior setup: protocol violation. Ignored; PREADY stays 0.
- Address or control changes during ACCESS are ignored; the latched values are used.

## Timing
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM=IDLE, counter=0.
  - All memory words = 0.
- Outputs are registered: PREADY, PSLVERR and PRDATA are flop outputs.
  - The next value is computed from the FSM and counter, so PREADY can be 1 in the first ACCESS cycle.
- WAIT_STATES=0: setup T0, access T1 with PREADY=1; write commits at the end of T1.
- WAIT_STATES=N: PREADY=1 at T1+N.
- PREADY, PSLVERR and PRDATA≠0 are held exactly one cycle, then return to 0.
- Back-to-back transfers: the next setup may occupy the cycle directly after completion. Minimum 2+WAIT_STATES cycles per transfer.
- Write then read of the same address in consecutive transfers returns the new data; no hazard.
- PRESETn low mid-transfer:
  - Outputs and FSM return to reset values immediately, asynchronously.
  - Memory is cleared.
  - The in-flight write is lost.

## Structure
- Package apb_slave_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS}.
  - Default parameter constants.
  - Function addr_err(addr).
- Sub-module apb_slave_regfile holds the MEM_DEPTH×DATA_WIDTH flop array.
  - Ports: synchronous write-enable/index/data; combinational read index/data; async clear on PRESETn.
- The top holds the FSM, wait counter, latches and output flops.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 and read 0x04 with WAIT_STATES=0 → PREADY in T1 of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=3, write 0x12345678 to 0x10 → PREADY low for 3 access cycles, high on the 4th; readback matches.
- Write to 0x80 (index 32 ≥ MEM_DEPTH), then write to 0x06 (misaligned) → PSLVERR=1 with PREADY for each; read of 0x80 returns 0; mem[0] and mem[1] unchanged.
- Back-to-back: write 0x0C=0xA5A5A5A5, read 0x0C, read 0x00, with no idle cycles between transfers → data 0xA5A5A5A5 then 0, with each transfer taking 2+WAIT_STATES cycles.
- PSEL dropped in ACCESS of a write to 0x08 → no PREADY, mem[2] unchanged. Assert PRESETn low mid-read → PREADY=0 and PRDATA=0 immediately; earlier writes read back 0 after reset.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types, default parameters and the address-legality helper for the APB register memory.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_ADDR_WIDTH  = 8;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_MEM_DEPTH   = 32;
  localparam int unsigned DEF_WAIT_STATES = 1;
  localparam int unsigned CNT_W           = 4;

  // A byte address is illegal when it is not word aligned or lands past the last word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word storage behind the APB completer: one synchronous write port, one combinational read port.
module apb_slave_regfile #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Reset clears every word; otherwise commit the write the top has already qualified.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer with a fixed number of wait states and PSLVERR on illegal addresses.
//
// state  | meaning
// IDLE   | no transfer in flight
// SETUP  | setup captured; current cycle is the first access cycle
// ACCESS | later access cycles, wait counter running down
//
// PREADY/PSLVERR/PRDATA are flops whose next value is computed one cycle ahead
// from the next counter value, so a zero-wait transfer completes in its first
// access cycle.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  err_cur, err_nxt;

  assign err_cur = addr_err(32'(addr_q), MEM_DEPTH);
  assign err_nxt = addr_err(32'(addr_d), MEM_DEPTH);

  // Next-state, request capture, wait counter and completion decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    mem_we   = 1'b0;
    if (!PSEL) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!PENABLE) begin
      state_d  = SETUP;
      addr_d   = PADDR;
      write_d  = PWRITE;
      wdata_d  = PWDATA;
      cnt_d    = CNT_W'(WAIT_STATES);
      pready_d = (WAIT_STATES == 0);
    end else if (state_q != IDLE) begin
      if (pready_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        mem_we  = write_q && !err_cur;
      end else begin
        state_d  = ACCESS;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        pready_d = (cnt_d == '0);
      end
    end
  end

  // Response data is only presented on an error-free read completion.
  always_comb begin
    pslverr_d = pready_d && err_nxt;
    prdata_d  = (pready_d && !write_d && !err_nxt) ? mem_rdata : '0;
  end

  // FSM, captured request and wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered response; each value lives for exactly one cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slave_regfile #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .we_i      (mem_we),
    .wr_idx_i  (addr_q[IDX_W+1:2]),
    .wr_data_i (wdata_q),
    .rd_idx_i  (addr_d[IDX_W+1:2]),
    .rd_data_o (mem_rdata)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule
